// File: rtl/gbdt_sample_loader.sv
// gbdt_sample_loader: buffers one sample's features, runs the GBDT classifier
// and returns its score (or a framing/timeout error) on a valid/ready result port.
`default_nettype none

module gbdt_sample_loader #(
  parameter int N_FEAT  = 200,
  parameter int TIMEOUT = 65535
) (
  input  logic        gbdt_clk,
  input  logic        gbdt_rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [8:0]  s_data,
  input  logic        s_last,
  output logic        enable,
  input  logic [7:0]  feature_num,
  output logic [8:0]  feature_val,
  input  logic        class_done,
  input  logic [31:0] class_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_err,
  output logic        busy,
  output logic [15:0] sample_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_RUN    = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  localparam logic [8:0]  LAST_IDX    = 9'(N_FEAT - 1);
  localparam logic [15:0] WD_LAST     = 16'(TIMEOUT - 1);
  localparam logic [1:0]  ERR_OK      = 2'b00;
  localparam logic [1:0]  ERR_FRAME   = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

  state_e      state_q, state_d;
  logic [8:0]  load_cnt_q, load_cnt_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic [31:0] res_data_q, res_data_d;
  logic [1:0]  res_err_q, res_err_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic        s_ready_q, enable_q, busy_q, res_valid_q;
  logic [8:0]  feat_q [N_FEAT];

  logic beat, store, frame_err;

  assign beat  = s_valid && s_ready_q;
  assign store = beat && ((state_q == ST_IDLE) || (state_q == ST_LOAD));

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    wd_cnt_d     = '0;
    res_data_d   = res_data_q;
    res_err_d    = res_err_q;
    sample_cnt_d = sample_cnt_q;
    frame_err    = 1'b0;

    if (store) load_cnt_d = load_cnt_q + 9'd1;

    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          if (s_last) frame_err = 1'b1;
          else        state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          if (load_cnt_q == LAST_IDX) state_d = s_last ? ST_RUN : ST_DRAIN;
          else if (s_last)            frame_err = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (beat && s_last) frame_err = 1'b1;
      end
      ST_RUN: begin
        wd_cnt_d = wd_cnt_q + 16'd1;
        // A completion in the same cycle as the watchdog expiry still counts.
        if (class_done) begin
          res_data_d = class_result;
          res_err_d  = ERR_OK;
          state_d    = ST_RESULT;
        end else if (wd_cnt_q == WD_LAST) begin
          res_data_d = '0;
          res_err_d  = ERR_TIMEOUT;
          state_d    = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_valid_q && res_ready) begin
          sample_cnt_d = sample_cnt_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_err) begin
      res_data_d = '0;
      res_err_d  = ERR_FRAME;
      state_d    = ST_RESULT;
    end

    if (state_d == ST_IDLE) load_cnt_d = '0;
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      state_q      <= ST_IDLE;
      load_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      res_data_q   <= '0;
      res_err_q    <= ERR_OK;
      sample_cnt_q <= '0;
      s_ready_q    <= 1'b1;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      res_data_q   <= res_data_d;
      res_err_q    <= res_err_d;
      sample_cnt_q <= sample_cnt_d;
      s_ready_q    <= (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DRAIN);
      enable_q     <= (state_d == ST_RUN);
      busy_q       <= (state_d != ST_IDLE);
      res_valid_q  <= (state_d == ST_RESULT);
    end
  end

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      for (int i = 0; i < N_FEAT; i++) feat_q[i] <= '0;
    end else if (store) begin
      for (int i = 0; i < N_FEAT; i++) begin
        if (load_cnt_q == 9'(i)) feat_q[i] <= s_data;
      end
    end
  end

  // Out-of-range indices match no entry and read as zero.
  always_comb begin
    feature_val = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if ({1'b0, feature_num} == 9'(i)) feature_val = feat_q[i];
    end
  end

  assign s_ready    = s_ready_q;
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign sample_cnt = sample_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gbdt_sample_loader.sv
// Self-checking bench for gbdt_sample_loader: directed samples against a
// feature/score model plus per-cycle checks of the output rules.
`default_nettype none

module tb_gbdt_sample_loader;

  localparam int NF  = 4;
  localparam int TO  = 10;
  localparam int NF2 = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_valid, s_ready, s_last, enable, class_done, res_valid, res_ready, busy;
  logic [8:0]  s_data, feature_val;
  logic [7:0]  feature_num;
  logic [31:0] class_result, res_data;
  logic [1:0]  res_err;
  logic [15:0] sample_cnt;

  logic        s_valid2, s_ready2, s_last2, enable2, res_valid2, busy2;
  logic [8:0]  s_data2, feature_val2;
  logic [7:0]  feature_num2;
  logic [31:0] res_data2;
  logic [1:0]  res_err2;
  logic [15:0] sample_cnt2;

  gbdt_sample_loader #(.N_FEAT(NF), .TIMEOUT(TO)) dut (
    .gbdt_clk(clk), .gbdt_rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .enable(enable), .feature_num(feature_num), .feature_val(feature_val),
    .class_done(class_done), .class_result(class_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy), .sample_cnt(sample_cnt)
  );

  gbdt_sample_loader #(.N_FEAT(NF2)) dut2 (
    .gbdt_clk(clk), .gbdt_rst_n(rst_n),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .s_last(s_last2),
    .enable(enable2), .feature_num(feature_num2), .feature_val(feature_val2),
    .class_done(1'b0), .class_result(32'h0),
    .res_valid(res_valid2), .res_ready(1'b1), .res_data(res_data2),
    .res_err(res_err2), .busy(busy2), .sample_cnt(sample_cnt2)
  );

  int total = 0;
  int bad   = 0;

  // Model: stored features, accepted-result count and the score now expected.
  logic [8:0]  m_feat  [NF];
  logic [8:0]  m_feat2 [NF2];
  int          m_cnt;
  logic [31:0] m_rdata;
  logic [1:0]  m_rerr;
  int          en_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int fi;
    logic [8:0] e;
    fi = int'(feature_num);
    e  = (fi < NF) ? m_feat[fi] : 9'd0;
    check("feature_val", {23'd0, feature_val}, {23'd0, e});
    fi = int'(feature_num2);
    e  = (fi < NF2) ? m_feat2[fi] : 9'd0;
    check("feature_val2", {23'd0, feature_val2}, {23'd0, e});
    check("sample_cnt", {16'd0, sample_cnt}, {16'd0, m_cnt[15:0]});
    check("s_ready_rule", {31'd0, s_ready}, {31'd0, !(enable || res_valid)});
    check("run_result_exclusive", {31'd0, enable & res_valid}, 32'd0);
    if (enable || res_valid) check("busy_rule", {31'd0, busy}, 32'd1);
    if (res_valid) begin
      check("res_data", res_data, m_rdata);
      check("res_err", {30'd0, res_err}, {30'd0, m_rerr});
    end
    if (enable) en_cycles++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [8:0] d, input logic last, input int idx);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (idx < NF) m_feat[idx] = d;
  endtask

  task automatic load_full(input int base);
    for (int i = 0; i < NF; i++) beat(9'(base + 3 * i), (i == NF - 1), i);
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    check({name, "_res_valid"}, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    m_cnt++;
    check("accept_res_valid_drop", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic clear_models();
    for (int i = 0; i < NF; i++)  m_feat[i]  = '0;
    for (int i = 0; i < NF2; i++) m_feat2[i] = '0;
    m_cnt = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0;
    s_valid = 0; s_data = 0; s_last = 0; feature_num = 0;
    class_done = 0; class_result = 0; res_ready = 0;
    s_valid2 = 0; s_data2 = 0; s_last2 = 0; feature_num2 = 8'd250;
    m_rdata = 0; m_rerr = 0; en_cycles = 0;
    clear_models();
    repeat (3) step();

    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_err", {30'd0, res_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sample_cnt", {16'd0, sample_cnt}, 32'd0);
    check("rst_feature_val", {23'd0, feature_val}, 32'd0);
    check("rst2_feature_val_oor", {23'd0, feature_val2}, 32'd0);
    check("rst2_res", {res_data2[31:3], res_err2, res_valid2}, 32'd0);
    check("rst2_sample_cnt", {16'd0, sample_cnt2}, 32'd0);
    rst_n = 1'b1;
    step();

    // Nominal sample
    feature_num = 8'd2;
    beat(9'd5, 1'b0, 0);
    beat(9'd9, 1'b0, 1);
    beat(9'd300, 1'b0, 2);
    check("t1_enable_before_last", {31'd0, enable}, 32'd0);
    beat(9'd511, 1'b1, 3);
    check("t1_enable", {31'd0, enable}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_feature_val_2", {23'd0, feature_val}, 32'd300);
    m_rdata = 32'h0001_2345; m_rerr = 2'b00;
    class_done = 1'b1; class_result = 32'h0001_2345;
    step();
    class_done = 1'b0; class_result = 32'h0;
    check("t1_res_valid", {31'd0, res_valid}, 32'd1);
    check("t1_enable_off", {31'd0, enable}, 32'd0);
    check("t1_res_data", res_data, 32'h0001_2345);
    check("t1_res_err", {30'd0, res_err}, 32'd0);
    accept();
    check("t1_sample_cnt", {16'd0, sample_cnt}, 32'd1);
    check("t1_s_ready_idle", {31'd0, s_ready}, 32'd1);

    // Early s_last
    en_cycles = 0; m_rdata = 0; m_rerr = 2'b01; feature_num = 8'd1;
    beat(9'd17, 1'b0, 0);
    beat(9'd42, 1'b1, 1);
    check("t2_res_valid", {31'd0, res_valid}, 32'd1);
    check("t2_res_err", {30'd0, res_err}, 32'd1);
    check("t2_res_data", res_data, 32'd0);
    check("t2_feature_val_1", {23'd0, feature_val}, 32'd42);
    step(); step();
    check("t2_enable_never", en_cycles, 32'd0);
    accept();

    // Late s_last: indices 4 and 5 are drained
    en_cycles = 0; m_rdata = 0; m_rerr = 2'b01; feature_num = 8'd3;
    for (int i = 0; i < NF; i++) beat(9'(100 + i), 1'b0, i);
    check("t3_ready_drain4", {31'd0, s_ready}, 32'd1);
    check("t3_busy_drain", {31'd0, busy}, 32'd1);
    beat(9'd77, 1'b0, 4);
    check("t3_ready_drain5", {31'd0, s_ready}, 32'd1);
    beat(9'd78, 1'b1, 5);
    check("t3_res_valid", {31'd0, res_valid}, 32'd1);
    check("t3_res_err", {30'd0, res_err}, 32'd1);
    check("t3_feature_val_3", {23'd0, feature_val}, 32'd103);
    check("t3_enable_never", en_cycles, 32'd0);
    accept();

    // Watchdog expiry
    en_cycles = 0; m_rdata = 0; m_rerr = 2'b10;
    load_full(20);
    wait_result("t4");
    check("t4_enable_cycles", en_cycles, TO);
    check("t4_res_err", {30'd0, res_err}, 32'd2);
    check("t4_res_data", res_data, 32'd0);
    accept();

    // Completion in the last RUN cycle beats the watchdog
    en_cycles = 0;
    load_full(40);
    m_rdata = 32'hDEAD_BEEF; m_rerr = 2'b00;
    repeat (TO - 1) step();
    check("t4b_enable_still", {31'd0, enable}, 32'd1);
    class_done = 1'b1; class_result = 32'hDEAD_BEEF;
    step();
    class_done = 1'b0; class_result = 32'h0;
    check("t4b_res_valid", {31'd0, res_valid}, 32'd1);
    check("t4b_res_err", {30'd0, res_err}, 32'd0);
    check("t4b_res_data", res_data, 32'hDEAD_BEEF);
    check("t4b_enable_cycles", en_cycles, TO);
    accept();

    // Downstream stall with a stray class_done
    m_rdata = 32'hCAFE_0042; m_rerr = 2'b00;
    load_full(60);
    class_done = 1'b1; class_result = 32'hCAFE_0042;
    step();
    for (int i = 0; i < 20; i++) begin
      class_done   = (i == 7);
      class_result = (i == 7) ? 32'h0BAD_0BAD : 32'h0;
      step();
      check("t5_stall_res_valid", {31'd0, res_valid}, 32'd1);
      check("t5_stall_s_ready", {31'd0, s_ready}, 32'd0);
    end
    class_done = 1'b0;
    check("t5_res_data_held", res_data, 32'hCAFE_0042);
    accept();
    check("t5_sample_cnt", {16'd0, sample_cnt}, 32'd6);
    feature_num = 8'd250;
    #1;
    check("t5_oor_small", {23'd0, feature_val}, 32'd0);

    // Out-of-range read on the 200-feature instance
    for (int i = 0; i < NF2; i++) begin
      s_valid2 = 1'b1;
      s_data2  = 9'((i * 7 + 3) % 512);
      s_last2  = (i == NF2 - 1);
      step();
      m_feat2[i] = 9'((i * 7 + 3) % 512);
    end
    s_valid2 = 1'b0; s_last2 = 1'b0;
    check("t5_dut2_enable", {31'd0, enable2}, 32'd1);
    check("t5_dut2_busy", {31'd0, busy2}, 32'd1);
    check("t5_dut2_s_ready", {31'd0, s_ready2}, 32'd0);
    feature_num2 = 8'd250;
    #1;
    check("t5_oor_250", {23'd0, feature_val2}, 32'd0);
    feature_num2 = 8'd199;
    #1;
    check("t5_feat_199", {23'd0, feature_val2}, 32'd372);
    feature_num2 = 8'd0;
    #1;
    check("t5_feat_0", {23'd0, feature_val2}, 32'd3);
    step();

    // Reset in RUN
    feature_num = 8'd1;
    load_full(80);
    step(); step();
    check("t6_enable_pre", {31'd0, enable}, 32'd1);
    rst_n = 1'b0;
    clear_models();
    #1;
    check("t6_enable_async", {31'd0, enable}, 32'd0);
    check("t6_busy_async", {31'd0, busy}, 32'd0);
    check("t6_s_ready_async", {31'd0, s_ready}, 32'd1);
    check("t6_feature_val_cleared", {23'd0, feature_val}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("t6_sample_cnt_zero", {16'd0, sample_cnt}, 32'd0);
    en_cycles = 0;
    load_full(200);
    check("t6_feature_val_1", {23'd0, feature_val}, 32'd203);
    m_rdata = 32'h0000_7777; m_rerr = 2'b00;
    step();
    class_done = 1'b1; class_result = 32'h0000_7777;
    step();
    class_done = 1'b0; class_result = 32'h0;
    check("t6_res_data", res_data, 32'h0000_7777);
    check("t6_res_err", {30'd0, res_err}, 32'd0);
    check("t6_enable_cycles", en_cycles, 32'd2);
    accept();
    check("t6_sample_cnt", {16'd0, sample_cnt}, 32'd1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
